// File: rtl/circulant_router_param.sv
// circulant_router_param: one router of the circulant network C(NODE_COUNT; S1, S2).
// Per-input FIFOs, minimal-hop route table, round-robin arbitration, registered outputs.
module circulant_router_param #(
  parameter int NODE_COUNT = 5,
  parameter int S1 = 1,
  parameter int S2 = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PAYLOAD_W = 8,
  parameter int ADDR_W = $clog2(NODE_COUNT),
  parameter int STEP_W = ADDR_W + 1,
  parameter int FLIT_W = 2*STEP_W + PAYLOAD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   router_name,
  input  logic [4:0]          in_valid,
  input  logic [5*FLIT_W-1:0] in_data,
  output logic [4:0]          in_ready,
  output logic [4:0]          out_valid,
  output logic [5*FLIT_W-1:0] out_data,
  input  logic [4:0]          out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 2*STEP_W;

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  // Entry k holds {step1, step2}: fewest hops, then smallest |step2|, then non-negative signs.
  function automatic logic [NODE_COUNT*RW-1:0] build_routes();
    logic [NODE_COUNT*RW-1:0] t;
    int h, ba, bb, ca, cb;
    bit found, better;
    t = '0;
    h = NODE_COUNT / 2;
    for (int k = 0; k < NODE_COUNT; k++) begin
      ba = 0;
      bb = 0;
      found = 0;
      for (int a = -h; a <= h; a++)
        for (int b = -h; b <= h; b++) begin
          ca = iabs(a) + iabs(b);
          cb = iabs(ba) + iabs(bb);
          better = !found || ca < cb || (ca == cb && (iabs(b) < iabs(bb) ||
                   (iabs(b) == iabs(bb) && ((a >= 0 && ba < 0) ||
                   ((a >= 0) == (ba >= 0) && b >= 0 && bb < 0)))));
          if ((((a*S1 + b*S2) % NODE_COUNT) + NODE_COUNT) % NODE_COUNT == k && better) begin
            found = 1;
            ba = a;
            bb = b;
          end
        end
      t[k*RW +: RW] = {STEP_W'(ba), STEP_W'(bb)};
    end
    return t;
  endfunction

  localparam logic [NODE_COUNT*RW-1:0] ROUTES = build_routes();

  logic [FLIT_W-1:0]        mem [5][FIFO_DEPTH];
  logic [PW-1:0]            wr [5];
  logic [PW-1:0]            rd [5];
  logic [CW-1:0]            cnt [5];
  logic [FLIT_W-1:0]        head [5];
  logic [FLIT_W-1:0]        nflit [5];
  logic [FLIT_W-1:0]        sel [5];
  logic signed [STEP_W-1:0] st1 [5];
  logic signed [STEP_W-1:0] st2 [5];
  logic signed [STEP_W-1:0] ns1 [5];
  logic signed [STEP_W-1:0] ns2 [5];
  logic [2:0]               dest [5];
  logic [2:0]               ptr [5];
  logic [2:0]               gidx [5];
  logic [4:0]               push, pop, load, gv;
  logic [ADDR_W:0]          kraw, kidx;
  logic [RW-1:0]            lroute;

  assign kraw = {1'b0, mem[0][rd[0]][PAYLOAD_W +: ADDR_W]} + (ADDR_W+1)'(NODE_COUNT) - {1'b0, router_name};
  assign kidx = kraw >= (ADDR_W+1)'(NODE_COUNT) ? kraw - (ADDR_W+1)'(NODE_COUNT) : kraw;
  assign lroute = ROUTES[kidx*RW +: RW];
  assign push = in_valid & in_ready;
  assign load = ~out_valid | out_ready;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      in_ready[i] = cnt[i] < CW'(FIFO_DEPTH);
      head[i] = mem[i][rd[i]];
      {st1[i], st2[i]} = i == 0 ? lroute : head[i][PAYLOAD_W +: RW];
      dest[i] = st1[i] > 0 ? 3'd1 : st1[i] < 0 ? 3'd3 : st2[i] > 0 ? 3'd2 : st2[i] < 0 ? 3'd4 : 3'd0;
      ns1[i] = st1[i] > 0 ? st1[i] - STEP_W'(1) : st1[i] < 0 ? st1[i] + STEP_W'(1) : st1[i];
      ns2[i] = st1[i] != 0 ? st2[i] : st2[i] > 0 ? st2[i] - STEP_W'(1) :
               st2[i] < 0 ? st2[i] + STEP_W'(1) : st2[i];
      nflit[i] = {ns1[i], ns2[i], head[i][PAYLOAD_W-1:0]};
    end
  end

  // Scanning from the farthest offset down leaves the first requester at/after the pointer.
  always_comb begin
    int c;
    c = 0;
    pop = '0;
    gv = '0;
    for (int o = 0; o < 5; o++) begin
      gidx[o] = ptr[o];
      for (int i = 4; i >= 0; i--) begin
        c = int'(ptr[o]) + i;
        c = c >= 5 ? c - 5 : c;
        if (load[o] && cnt[c] != '0 && dest[c] == 3'(o)) begin
          gv[o] = 1'b1;
          gidx[o] = 3'(c);
        end
      end
      sel[o] = nflit[gidx[o]];
      pop = pop | (gv[o] ? 5'b1 << gidx[o] : 5'b0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (push[i]) mem[i][wr[i]] <= in_data[i*FLIT_W +: FLIT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        wr[i] <= '0;
        rd[i] <= '0;
        cnt[i] <= '0;
        ptr[i] <= '0;
      end
      out_valid <= '0;
      out_data <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        wr[i] <= wr[i] + PW'(push[i]);
        rd[i] <= rd[i] + PW'(pop[i]);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
        if (load[i]) out_valid[i] <= gv[i];
        if (gv[i]) begin
          out_data[i*FLIT_W +: FLIT_W] <= sel[i];
          ptr[i] <= gidx[i] == 3'd4 ? 3'd0 : gidx[i] + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_circulant_router_param.sv
// tb_circulant_router_param: directed scenarios plus randomized traffic against a
// reference model that searches routes by hop cost and tracks per-input order per output.
module tb_circulant_router_param;
  localparam int N = 5, AW = 3, SW = 4, PL = 8, FW = 16;
  logic clk = 0;
  logic rst;
  logic [AW-1:0] router_name;
  logic [4:0] in_valid, in_ready, out_valid, out_ready;
  logic [5*FW-1:0] in_data, out_data;
  int checks = 0, errors = 0;
  logic [FW+2:0] sbq [5][$];

  always #5 clk = ~clk;

  circulant_router_param #(.NODE_COUNT(5), .S1(1), .S2(2), .FIFO_DEPTH(4), .PAYLOAD_W(8)) dut (
    .clk(clk), .rst(rst), .router_name(router_name), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready));

  function automatic logic [FW-1:0] mk(input int a, input int b, input int pl);
    return {SW'(a), SW'(b), PL'(pl)};
  endfunction

  function automatic int modn(input int v);
    return ((v % N) + N) % N;
  endfunction

  // Walk candidates in increasing hop cost, then |b|, then a>=0, then b>=0; first hit wins.
  function automatic void min_route(input int k, output int ra, output int rb);
    bit found;
    int a, b;
    found = 0;
    ra = 0;
    rb = 0;
    for (int c = 0; c <= 2*(N/2); c++)
      for (int mb = 0; mb <= c; mb++)
        for (int sa = 1; sa >= -1; sa -= 2)
          for (int sb = 1; sb >= -1; sb -= 2) begin
            a = sa * (c - mb);
            b = sb * mb;
            if (!found && c - mb <= N/2 && mb <= N/2 && modn(a*1 + b*2) == k) begin
              found = 1;
              ra = a;
              rb = b;
            end
          end
  endfunction

  function automatic void model(input int src, input logic [FW-1:0] f, input int name,
                                output int port, output logic [FW-1:0] of);
    int a, b;
    if (src == 0) min_route(modn(int'(f[PL +: AW]) - name), a, b);
    else begin
      a = int'($signed(f[FW-1 -: SW]));
      b = int'($signed(f[PL +: SW]));
    end
    port = 0;
    if (a != 0) begin
      port = a > 0 ? 1 : 3;
      a = a > 0 ? a - 1 : a + 1;
    end else if (b != 0) begin
      port = b > 0 ? 2 : 4;
      b = b > 0 ? b - 1 : b + 1;
    end
    of = mk(a, b, int'(f[PL-1:0]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic v, input logic [FW-1:0] f);
    in_valid[p] = v;
    in_data[p*FW +: FW] = f;
  endtask

  task automatic do_reset(input int name);
    rst = 1;
    router_name = AW'(name);
    in_valid = '0;
    in_data = '0;
    out_ready = '1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    router_name = '0;
    in_valid = '0;
    in_data = '0;
    out_ready = '1;
    #1;
    checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL reset_out_valid got %b want 00000", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tick();
    rst = 0;
    #1;
    checks++; if (in_ready !== 5'h1F) begin errors++; $display("FAIL reset_in_ready got %b want 11111", in_ready); end
    checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL reset_idle got %b want 00000", out_valid); end
  endtask

  task automatic test_local_route();
    logic [FW-1:0] f, of;
    int port;
    do_reset(0);
    f = {5'b0, 3'd3, 8'hA5};
    model(0, f, 0, port, of);
    put(0, 1, f);
    tick();
    put(0, 0, '0);
    tick();
    checks++; if (out_valid !== 5'(1 << port)) begin errors++; $display("FAIL local_valid got %b want %b", out_valid, 5'(1 << port)); end
    checks++; if (out_data[port*FW +: FW] !== of) begin errors++; $display("FAIL local_model_data got %h want %h", out_data[port*FW +: FW], of); end
    checks++; if (out_data[4*FW +: FW] !== 16'h00A5) begin errors++; $display("FAIL local_r2L_data got %h want 00a5", out_data[4*FW +: FW]); end
    tick();
    checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL local_drain got %b want 00000", out_valid); end
  endtask

  task automatic test_eject();
    do_reset(2);
    put(0, 1, {5'b0, 3'd2, 8'h11});
    tick();
    put(0, 0, '0);
    tick();
    checks++; if (out_valid !== 5'b00001) begin errors++; $display("FAIL eject_valid got %b want 00001", out_valid); end
    checks++; if (out_data[0 +: FW] !== 16'h0011) begin errors++; $display("FAIL eject_data got %h want 0011", out_data[0 +: FW]); end
  endtask

  task automatic test_link();
    put(3, 1, mk(2, -1, 8'h33));
    tick();
    put(3, 1, mk(0, -1, 8'h44));
    tick();
    checks++; if (out_valid[1] !== 1'b1 || out_data[FW +: FW] !== mk(1, -1, 8'h33)) begin
      errors++; $display("FAIL link_r1R got v=%b %h want v=1 %h", out_valid[1], out_data[FW +: FW], mk(1, -1, 8'h33)); end
    put(3, 0, '0);
    tick();
    checks++; if (out_valid[4] !== 1'b1 || out_data[4*FW +: FW] !== mk(0, 0, 8'h44)) begin
      errors++; $display("FAIL link_r2L got v=%b %h want v=1 %h", out_valid[4], out_data[4*FW +: FW], mk(0, 0, 8'h44)); end
  endtask

  task automatic test_round_robin();
    logic [FW-1:0] exp;
    do_reset(0);
    for (int c = 0; c < 9; c++) begin
      put(2, c < 4, mk(1, 0, 8'h20 + c));
      put(3, c < 4, mk(1, 0, 8'h30 + c));
      tick();
      if (c >= 1) begin
        exp = mk(0, 0, ((c - 1) % 2 ? 8'h30 : 8'h20) + (c - 1) / 2);
        checks++; if (out_valid[1] !== 1'b1 || out_data[FW +: FW] !== exp) begin
          errors++; $display("FAIL rr_%0d got v=%b %h want v=1 %h", c - 1, out_valid[1], out_data[FW +: FW], exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset(0);
    out_ready = 5'b11101;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      put(3, 1, mk(1, 0, 8'h50 + acc));
      @(negedge clk);
      if (in_valid[3] && in_ready[3]) acc++;
      tick();
    end
    checks++; if (acc !== 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", acc); end
    checks++; if (in_ready[3] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready[3]); end
    checks++; if (out_valid[1] !== 1'b1 || out_data[FW +: FW] !== mk(0, 0, 8'h50)) begin
      errors++; $display("FAIL bp_hold got v=%b %h want v=1 %h", out_valid[1], out_data[FW +: FW], mk(0, 0, 8'h50)); end
    out_ready = '1;
    put(3, 0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid[1] !== 1'b1 || out_data[FW +: FW] !== mk(0, 0, 8'h50 + i)) begin
        errors++; $display("FAIL bp_drain_%0d got v=%b %h want v=1 %h", i, out_valid[1], out_data[FW +: FW], mk(0, 0, 8'h50 + i)); end
    end
    @(negedge clk);
    checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid[1]); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 5'b11101;
    for (int i = 0; i < 4; i++) begin
      put(3, 1, mk(1, 0, 8'h70 + i));
      tick();
    end
    put(3, 0, '0);
    checks++; if (out_valid[1] !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", out_valid[1]); end
    #2 rst = 1;
    #1;
    checks++; if (out_valid !== 5'b0 || out_data !== '0) begin errors++; $display("FAIL mid_async got %b %h want 00000 0", out_valid, out_data); end
    #2 rst = 0;
    out_ready = '1;
    checks++; if (in_ready !== 5'h1F) begin errors++; $display("FAIL mid_in_ready got %b want 11111", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_empty_%0d got %b want 00000", i, out_valid); end
    end
    put(1, 1, mk(1, 0, 8'h61));
    put(4, 1, mk(1, 0, 8'h64));
    tick();
    put(1, 0, '0);
    put(4, 0, '0);
    tick();
    checks++; if (out_data[FW +: FW] !== mk(0, 0, 8'h61)) begin errors++; $display("FAIL mid_ptr_first got %h want %h", out_data[FW +: FW], mk(0, 0, 8'h61)); end
    tick();
    checks++; if (out_data[FW +: FW] !== mk(0, 0, 8'h64)) begin errors++; $display("FAIL mid_ptr_second got %h want %h", out_data[FW +: FW], mk(0, 0, 8'h64)); end
  endtask

  task automatic test_random();
    logic [4:0] hold;
    logic [FW-1:0] f, of;
    int pay, port, idx;
    bit ok;
    do_reset(3);
    hold = '0;
    pay = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = cyc < 300 ? 5'($urandom) | 5'($urandom) : 5'h1F;
      for (int p = 0; p < 5; p++)
        if (!hold[p]) begin
          if (cyc < 300 && $urandom_range(0, 1) == 1) begin
            f = p == 0 ? {5'b0, 3'($urandom_range(0, N - 1)), 8'(pay)}
                       : mk(int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2, pay);
            pay++;
            put(p, 1, f);
          end else put(p, 0, '0);
        end
      @(negedge clk);
      for (int o = 0; o < 5; o++)
        if (out_valid[o] && out_ready[o]) begin
          idx = -1;
          for (int i = 0; i < sbq[o].size(); i++)
            if (idx < 0 && sbq[o][i][FW-1:0] == out_data[o*FW +: FW]) idx = i;
          ok = idx >= 0;
          for (int j = 0; j < idx; j++)
            if (sbq[o][j][FW+2:FW] == sbq[o][idx][FW+2:FW]) ok = 0;
          checks++; if (!ok) begin errors++; $display("FAIL random_out%0d got %h not next expected (idx %0d, pending %0d)", o, out_data[o*FW +: FW], idx, sbq[o].size()); end
          if (idx >= 0) sbq[o].delete(idx);
        end
      for (int p = 0; p < 5; p++)
        if (in_valid[p] && in_ready[p]) begin
          model(p, in_data[p*FW +: FW], 3, port, of);
          sbq[port].push_back({3'(p), of});
        end
      hold = in_valid & ~in_ready;
      tick();
    end
    for (int o = 0; o < 5; o++) begin
      checks++; if (sbq[o].size() != 0) begin errors++; $display("FAIL random_lost_out%0d got %0d pending want 0", o, sbq[o].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_local_route();
    test_eject();
    test_link();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
